pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures the high time (duty) and rising-edge-to-rising-edge
//                time (period) of an asynchronous PWM input, in clk cycles.
//                A watchdog flags a static input when no rising edge has been
//                seen for TIMEOUT clocks.
//  Ports       : clk     - single clock, all state on its rising edge
//                reset   - synchronous, active-high reset
//                pwm_in  - PWM input, asynchronous to clk
//                duty    - clocks pwm_in was high in the last measured period
//                period  - clocks between the last two rising edges
//                valid   - one-cycle pulse marking a duty/period update
//                timeout - level, high while the input is static
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int PERIOD_BITS = 7,
    parameter int TIMEOUT     = 256,
    localparam int CNT_W      = PERIOD_BITS + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             timeout
);

    // FSM encoding
    localparam logic [1:0] ST_WAIT_EDGE = 2'd0;
    localparam logic [1:0] ST_MEASURE   = 2'd1;
    localparam logic [1:0] ST_TIMED_OUT = 2'd2;

    // TIMEOUT must stay below 2**CNT_W, so the counters can never wrap
    // before the watchdog fires.
    localparam logic [CNT_W-1:0] C_TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_timeout;

    logic             w_rise;
    logic             w_expired;

    // r_s1/r_s2 form the synchronizer; r_s3 only exists for edge detection.
    assign w_rise    = r_s2 & ~r_s3;
    // A rise in the same cycle always takes priority over the watchdog.
    assign w_expired = (r_period_cnt == C_TIMEOUT_CNT) & ~w_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_state      <= ST_WAIT_EDGE;
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_duty       <= '0;
            r_period     <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_s1    <= pwm_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= 1'b0;

            case (r_state)
                ST_WAIT_EDGE: begin
                    if (w_rise) begin
                        // First edge only opens a measurement window.
                        r_state      <= ST_MEASURE;
                        r_period_cnt <= C_ONE;
                        r_high_cnt   <= C_ONE;
                    end else if (w_expired) begin
                        r_state   <= ST_TIMED_OUT;
                        r_timeout <= 1'b1;
                        r_period  <= '0;
                        r_duty    <= r_s2 ? '1 : '0;
                        r_valid   <= 1'b1;
                    end else begin
                        r_period_cnt <= r_period_cnt + C_ONE;
                    end
                end

                ST_MEASURE: begin
                    if (w_rise) begin
                        // The rise cycle itself counts as the first high
                        // clock of the next period, hence the reload to 1.
                        r_duty       <= r_high_cnt;
                        r_period     <= r_period_cnt;
                        r_valid      <= 1'b1;
                        r_period_cnt <= C_ONE;
                        r_high_cnt   <= C_ONE;
                    end else if (w_expired) begin
                        r_state   <= ST_TIMED_OUT;
                        r_timeout <= 1'b1;
                        r_period  <= '0;
                        r_duty    <= r_s2 ? '1 : '0;
                        r_valid   <= 1'b1;
                    end else begin
                        r_period_cnt <= r_period_cnt + C_ONE;
                        if (r_s2) begin
                            r_high_cnt <= r_high_cnt + C_ONE;
                        end
                    end
                end

                ST_TIMED_OUT: begin
                    // Outputs frozen; only a new edge restarts measuring.
                    if (w_rise) begin
                        r_state      <= ST_MEASURE;
                        r_timeout    <= 1'b0;
                        r_period_cnt <= C_ONE;
                        r_high_cnt   <= C_ONE;
                    end
                end

                default: begin
                    r_state <= ST_WAIT_EDGE;
                end
            endcase
        end
    end

    assign duty    = r_duty;
    assign period  = r_period;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule
`default_nettype wire
